// File: rtl/l1_l2_arbiter_pkg.sv
// Shared types for the L1/L2 arbiter: cache line type, arbiter FSM states and grant encoding.
package l1_l2_arbiter_pkg;

    localparam int C_LINE_W = 128;

    typedef logic [C_LINE_W-1:0] lc3b_c_line;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10,
        DONE    = 2'b11
    } lc3b_arb_state;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/l1_l2_arbiter_checker.sv
// Protocol checker for the L1/L2 arbiter's D-side requester (bound alongside the arbiter).
module l1_l2_arbiter_checker (
    input logic clk,
    input logic reset,
    input logic d_read,
    input logic d_write
);

    // A D-cache request is either a line read or a writeback, never both
    property p_d_excl;
        @(posedge clk) disable iff (reset) !(d_read && d_write);
    endproperty

    a_d_excl: assert property (p_d_excl);

endmodule

// File: rtl/l1_l2_arbiter.sv
// Serialises I-cache and D-cache line misses onto one L2 port and routes responses back.
// Optional macro ARB_RR_EN: round-robin between I and D instead of fixed D-over-I priority.
module l1_l2_arbiter
    import l1_l2_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    lc3b_arb_state state_r;
    logic          d_req_s;
    logic          pick_d_s;

    assign d_req_s = d_read | d_write;

`ifdef ARB_RR_EN
    logic last_grant_r;
    // On a tie, D wins only if I was granted last
    assign pick_d_s = (last_grant_r == GRANT_I);
`else
    assign pick_d_s = 1'b1;
`endif

    // Arbitration FSM; DONE forces one dead cycle so a stale request is never re-granted
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
`ifdef ARB_RR_EN
            last_grant_r <= GRANT_I;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (d_req_s && (!i_read || pick_d_s)) begin
                        state_r <= SERVE_D;
`ifdef ARB_RR_EN
                        last_grant_r <= GRANT_D;
`endif
                    end else if (i_read) begin
                        state_r <= SERVE_I;
`ifdef ARB_RR_EN
                        last_grant_r <= GRANT_I;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SERVE_I: state_r <= l2_resp ? DONE : SERVE_I;
                SERVE_D: state_r <= l2_resp ? DONE : SERVE_D;
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Read lines pass straight through; only the completion pulses are steered
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

    // L2 request mux and response steering; reset blanks everything in its own cycle
    always_comb begin
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_address = {ADDR_W{1'b0}};
        l2_wdata   = {LINE_W{1'b0}};
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        if (reset) begin
            l2_read  = 1'b0;
            l2_write = 1'b0;
        end else begin
            case (state_r)
                SERVE_I: begin
                    l2_read    = 1'b1;
                    l2_address = i_address;
                    i_resp     = l2_resp;
                end
                SERVE_D: begin
                    l2_read    = d_read;
                    l2_write   = d_write;
                    l2_address = d_address;
                    l2_wdata   = d_wdata;
                    d_resp     = l2_resp;
                end
                default: begin
                    l2_read  = 1'b0;
                    l2_write = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Self-checking bench for l1_l2_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_l1_l2_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_address = '0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_address = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata = '0;
    logic              l2_resp = 1'b0;

    l1_l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    l1_l2_arbiter_checker u_chk (.clk(clk), .reset(reset), .d_read(d_read), .d_write(d_write));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: who currently owns L2 (0 none, 1 I, 2 D), dead-cycle flag, last winner
    int m_owner = 0;
    int m_hold = 0;
    int m_last = 1;
    int lat_cnt = 0;
    int lat_target = 0;
    int lat_min = 0;
    int lat_max = 0;
    int i_done = 0;
    int d_done = 0;
    int grant_q[$];
    int grant_cyc_q[$];
    int resp_cyc_q[$];

    // Requester / L2 behaviour knobs
    bit i_auto = 0, d_auto = 0, i_eager = 0, d_eager = 0;
    int i_todo = 0, d_todo = 0;
    bit spurious_en = 0;
    bit force_resp = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic issue_i();
        i_read    = 1'b1;
        i_address = ADDR_W'($urandom) & 16'hFFF0;
        i_todo--;
    endtask

    task automatic issue_d();
        if ($urandom_range(0, 1) == 0) begin
            d_read = 1'b1;
        end else begin
            d_write = 1'b1;
        end
        d_address = ADDR_W'($urandom) & 16'hFFF0;
        d_wdata   = {$urandom, $urandom, $urandom, $urandom};
        d_todo--;
    endtask

    // One clock: drive L2 response, check outputs at negedge, advance model, update requesters
    task automatic cycle();
        logic              e_rd, e_wr, e_ir, e_dr;
        logic [ADDR_W-1:0] e_addr;
        logic [LINE_W-1:0] e_wd;
        bit                ir_pulse, dr_pulse;
        bit                want_i, want_d;
        ir_pulse = 0;
        dr_pulse = 0;
        l2_rdata = {$urandom, $urandom, $urandom, $urandom};
        l2_resp  = 1'b0;
        if (force_resp) l2_resp = 1'b1;
        else if (m_owner != 0 && lat_cnt >= lat_target) l2_resp = 1'b1;
        else if (m_owner == 0 && spurious_en && $urandom_range(0, 3) == 0) l2_resp = 1'b1;
        #4;
        e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
        e_addr = '0; e_wd = '0;
        if (!reset && m_owner == 1) begin
            e_rd = 1'b1; e_addr = i_address; e_ir = l2_resp;
        end
        if (!reset && m_owner == 2) begin
            e_rd = d_read; e_wr = d_write; e_addr = d_address; e_wd = d_wdata; e_dr = l2_resp;
        end
        check("l2_read", l2_read, e_rd);
        check("l2_write", l2_write, e_wr);
        check("l2_address", l2_address, e_addr);
        check("l2_wdata", l2_wdata, e_wd);
        check("i_resp", i_resp, e_ir);
        check("d_resp", d_resp, e_dr);
        check("i_rdata", i_rdata, l2_rdata);
        check("d_rdata", d_rdata, l2_rdata);
        @(posedge clk);
        if (reset) begin
            m_owner = 0; m_hold = 0; m_last = 1;
        end else if (m_owner != 0) begin
            lat_cnt++;
            if (l2_resp) begin
                if (m_owner == 1) begin i_done++; ir_pulse = 1; end
                else begin d_done++; dr_pulse = 1; end
                resp_cyc_q.push_back(cyc);
                m_owner = 0;
                m_hold  = 1;
            end
        end else if (m_hold != 0) begin
            m_hold = 0;
        end else begin
            want_i = i_read;
            want_d = d_read | d_write;
            if (want_i && want_d) begin
`ifdef ARB_RR_EN
                m_owner = (m_last == 1) ? 2 : 1;
`else
                m_owner = 2;
`endif
            end else if (want_d) m_owner = 2;
            else if (want_i) m_owner = 1;
            if (m_owner != 0) begin
                m_last     = m_owner;
                lat_cnt    = 0;
                lat_target = $urandom_range(lat_min, lat_max);
                grant_q.push_back(m_owner);
                grant_cyc_q.push_back(cyc + 1);
            end
        end
        #1;
        cyc++;
        if (ir_pulse) i_read = 1'b0;
        if (dr_pulse) begin d_read = 1'b0; d_write = 1'b0; end
        if (!i_read && i_auto && i_todo > 0 && (i_eager || $urandom_range(0, 2) == 0)) issue_i();
        if (!d_read && !d_write && d_auto && d_todo > 0 && (d_eager || $urandom_range(0, 2) == 0)) issue_d();
    endtask

    task automatic clear_logs();
        i_done = 0; d_done = 0;
        grant_q.delete(); grant_cyc_q.delete(); resp_cyc_q.delete();
    endtask

    task automatic run_until(input int want_i, input int want_d, input int budget, input string tag);
        for (int k = 0; k < budget; k++) begin
            if (i_done >= want_i && d_done >= want_d) break;
            cycle();
        end
        check(tag, {32'(i_done), 32'(d_done)}, {32'(want_i), 32'(want_d)});
    endtask

    task automatic drain(input int budget, input string tag);
        for (int k = 0; k < budget; k++) begin
            if (!i_read && !d_read && !d_write && m_owner == 0) break;
            cycle();
        end
        check(tag, {i_read, d_read, d_write}, 3'b000);
    endtask

    initial begin
        int bad;
        // Reset
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Single I read at 0x1230, response after 4 cycles
        clear_logs();
        lat_min = 4; lat_max = 4;
        i_read = 1'b1; i_address = 16'h1230;
        run_until(1, 0, 20, "i_single_done");
        check("i_single_no_d", 32'(d_done), 32'd0);
        repeat (3) cycle();

        // D writeback at 0x4440, response after 2 cycles
        clear_logs();
        lat_min = 2; lat_max = 2;
        d_write = 1'b1; d_address = 16'h4440; d_wdata = {8{16'hA5A5}};
        run_until(0, 1, 20, "d_wb_done");
        repeat (3) cycle();

        // Simultaneous D read 0x8000 and I read 0x0100
        clear_logs();
        lat_min = 3; lat_max = 3;
        d_read = 1'b1; d_address = 16'h8000;
        i_read = 1'b1; i_address = 16'h0100;
        run_until(1, 1, 40, "tie_both_done");
`ifdef ARB_RR_EN
        check("tie_first", 32'(grant_q[0]), 32'd1);
`else
        check("tie_first", 32'(grant_q[0]), 32'd2);
`endif
        check("tie_spacing", 32'(grant_cyc_q[1] - resp_cyc_q[0]), 32'd3);
        repeat (3) cycle();

        // Both sides re-request immediately after every completion
        clear_logs();
        lat_min = 1; lat_max = 1;
        i_auto = 1; d_auto = 1; i_eager = 1; d_eager = 1;
        i_todo = 1000; d_todo = 1000;
        repeat (40) cycle();
        bad = 0;
        for (int k = 1; k < grant_q.size(); k++) begin
            if (grant_q[k] == grant_q[k-1]) bad++;
        end
`ifdef ARB_RR_EN
        check("rr_alternate", 32'(bad), 32'd0);
`else
        check("fixed_i_starves", 32'(i_done), 32'd0);
`endif
        check("b2b_progress", 32'(grant_q.size() >= 6), 32'd1);
        i_todo = 0; d_todo = 0; i_eager = 0; d_eager = 0;
        drain(60, "b2b_drain");
        repeat (2) cycle();

        // Reset while SERVE_D waits for L2, then a late response in IDLE
        clear_logs();
        lat_min = 20; lat_max = 20;
        d_read = 1'b1; d_address = 16'h2220;
        repeat (3) cycle();
        check("rst_granted", 32'(grant_q.size()), 32'd1);
        reset = 1'b1; d_read = 1'b0;
        cycle();
        reset = 1'b0;
        force_resp = 1'b1;
        cycle();
        force_resp = 1'b0;
        repeat (3) cycle();
        check("rst_no_resp", 32'(d_done), 32'd0);

        // Spurious L2 response with nothing pending
        clear_logs();
        force_resp = 1'b1;
        cycle();
        force_resp = 1'b0;
        repeat (3) cycle();
        check("spurious_no_grant", 32'(grant_q.size()), 32'd0);

        // Randomized traffic with spurious responses
        clear_logs();
        lat_min = 0; lat_max = 5;
        spurious_en = 1;
        i_auto = 1; d_auto = 1;
        i_todo = 40; d_todo = 40;
        run_until(40, 40, 3000, "random_done");
        spurious_en = 0;
        drain(40, "random_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
